// File: rtl/vblank_scheduler.sv
// Grants exclusive frame-buffer access to one requester at a time during vertical blanking.
// Requesters are served round-robin, at most once per window, with a per-slot cycle limit.
module vblank_scheduler #(
  parameter int NREQ     = 4,
  parameter int VLAST    = 479,
  parameter int SLOT_MAX = 1023
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            video_on,
  input  logic [9:0]      y_control,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  input  logic            flag_clr,
  output logic [NREQ-1:0] grant,
  output logic            frame_tick,
  output logic            busy,
  output logic [15:0]     frame_count,
  output logic [NREQ-1:0] timeout_flag,
  output logic            overrun
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            videoOnDly_q;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] served_q, served_d;
  logic [NREQ-1:0] timeout_q, timeout_d;
  logic [PW-1:0]   rrPtr_q, rrPtr_d;
  logic [PW-1:0]   gIdx_q, gIdx_d;
  logic [15:0]     slot_q, slot_d;
  logic [15:0]     frameCount_q, frameCount_d;
  logic            tick_q, tick_d;
  logic            overrun_q, overrun_d;

  logic            vblankStart;
  logic            windowClose;
  logic            doneHit;
  logic            slotExpired;
  logic [NREQ-1:0] pending;
  logic            pickValid;
  logic [PW-1:0]   pickIdx;
  logic [PW-1:0]   nextPtr;

  assign vblankStart = videoOnDly_q & ~video_on & (y_control == 10'(VLAST));
  assign windowClose = ~videoOnDly_q & video_on;
  assign pending     = req & ~served_q;
  assign doneHit     = |(done & grant_q);
  assign slotExpired = (slot_q == 16'(SLOT_MAX));
  assign nextPtr     = (gIdx_q == PW'(NREQ - 1)) ? '0 : gIdx_q + PW'(1);

  // Cyclic search for the first pending requester starting at the round-robin pointer.
  always_comb begin
    int idx;
    idx       = 0;
    pickValid = 1'b0;
    pickIdx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rrPtr_q) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!pickValid && pending[idx]) begin
        pickValid = 1'b1;
        pickIdx   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    served_d     = served_q;
    rrPtr_d      = rrPtr_q;
    gIdx_d       = gIdx_q;
    slot_d       = slot_q;
    frameCount_d = frameCount_q;
    tick_d       = 1'b0;
    timeout_d    = flag_clr ? '0 : timeout_q;
    overrun_d    = flag_clr ? 1'b0 : overrun_q;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (vblankStart) begin
          state_d      = ARB;
          tick_d       = 1'b1;
          frameCount_d = frameCount_q + 16'd1;
          served_d     = '0;
        end
      end
      ARB: begin
        grant_d = '0;
        if (windowClose) begin
          state_d = IDLE;
        end else if (pickValid) begin
          grant_d          = '0;
          grant_d[pickIdx] = 1'b1;
          gIdx_d           = pickIdx;
          slot_d           = '0;
          state_d          = GRANT;
        end
      end
      GRANT: begin
        slot_d = slot_q + 16'd1;
        // Completion beats window close, which beats the slot timeout.
        if (doneHit) begin
          grant_d          = '0;
          served_d[gIdx_q] = 1'b1;
          rrPtr_d          = nextPtr;
          state_d          = ARB;
        end else if (windowClose) begin
          grant_d   = '0;
          overrun_d = 1'b1;
          state_d   = IDLE;
        end else if (slotExpired) begin
          grant_d           = '0;
          timeout_d[gIdx_q] = 1'b1;
          served_d[gIdx_q]  = 1'b1;
          rrPtr_d           = nextPtr;
          state_d           = ARB;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      videoOnDly_q <= 1'b0;
      grant_q      <= '0;
      served_q     <= '0;
      timeout_q    <= '0;
      rrPtr_q      <= '0;
      gIdx_q       <= '0;
      slot_q       <= '0;
      frameCount_q <= '0;
      tick_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      videoOnDly_q <= video_on;
      grant_q      <= grant_d;
      served_q     <= served_d;
      timeout_q    <= timeout_d;
      rrPtr_q      <= rrPtr_d;
      gIdx_q       <= gIdx_d;
      slot_q       <= slot_d;
      frameCount_q <= frameCount_d;
      tick_q       <= tick_d;
      overrun_q    <= overrun_d;
    end
  end

  assign grant        = grant_q;
  assign frame_tick   = tick_q;
  assign busy         = (state_q != IDLE);
  assign frame_count  = frameCount_q;
  assign timeout_flag = timeout_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_vblank_scheduler.sv
// Testbench for vblank_scheduler: directed table, corner-case sequences and a
// randomized run compared every cycle against a behavioural scheduler model.
module tb_vblank_scheduler;

  localparam int NREQ     = 4;
  localparam int VLAST    = 479;
  localparam int SLOT_MAX = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        video_on;
  logic [9:0]  y_control;
  logic [3:0]  req;
  logic [3:0]  done;
  logic        flag_clr;
  logic [3:0]  grant;
  logic        frame_tick;
  logic        busy;
  logic [15:0] frame_count;
  logic [3:0]  timeout_flag;
  logic        overrun;

  always #5 clk = ~clk;

  vblank_scheduler #(
    .NREQ(NREQ),
    .VLAST(VLAST),
    .SLOT_MAX(SLOT_MAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .video_on(video_on),
    .y_control(y_control),
    .req(req),
    .done(done),
    .flag_clr(flag_clr),
    .grant(grant),
    .frame_tick(frame_tick),
    .busy(busy),
    .frame_count(frame_count),
    .timeout_flag(timeout_flag),
    .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode 0 idle, 1 arbitrating, 2 a requester owns the buffer.
  bit        mVon;
  int        mMode;
  int        mOwner;
  int        mSlot;
  bit [3:0]  mServed;
  int        mRr;
  bit [15:0] mFc;
  bit        mTick;
  bit [3:0]  mTimeout;
  bit        mOverrun;

  typedef struct {
    logic        von;
    logic [9:0]  y;
    logic [3:0]  req;
    logic [3:0]  done;
    logic        clr;
    logic [3:0]  eGrant;
    logic        eTick;
    logic        eBusy;
    logic [15:0] eFc;
  } vec_t;

  vec_t tbl[21];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mVon     = 1'b0;
    mMode    = 0;
    mOwner   = 0;
    mSlot    = 0;
    mServed  = '0;
    mRr      = 0;
    mFc      = '0;
    mTick    = 1'b0;
    mTimeout = '0;
    mOverrun = 1'b0;
  endtask

  function automatic logic [3:0] modelGrant();
    return (mMode == 2) ? 4'(1 << mOwner) : 4'b0000;
  endfunction

  task automatic modelStep();
    bit vs;
    bit wc;
    vs    = mVon && !video_on && (y_control == 10'(VLAST));
    wc    = !mVon && video_on;
    mTick = 1'b0;
    if (flag_clr) begin
      mTimeout = '0;
      mOverrun = 1'b0;
    end
    case (mMode)
      0: begin
        if (vs) begin
          mMode   = 1;
          mTick   = 1'b1;
          mFc     = mFc + 16'd1;
          mServed = '0;
        end
      end
      1: begin
        if (wc) begin
          mMode = 0;
        end else begin
          for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (mRr + k) % NREQ;
            if (req[i] && !mServed[i]) begin
              mOwner = i;
              mSlot  = 0;
              mMode  = 2;
              break;
            end
          end
        end
      end
      default: begin
        if (done[mOwner]) begin
          mServed[mOwner] = 1'b1;
          mRr             = (mOwner + 1) % NREQ;
          mMode           = 1;
        end else if (wc) begin
          mOverrun = 1'b1;
          mMode    = 0;
        end else if (mSlot == SLOT_MAX) begin
          mTimeout[mOwner] = 1'b1;
          mServed[mOwner]  = 1'b1;
          mRr              = (mOwner + 1) % NREQ;
          mMode            = 1;
        end else begin
          mSlot = mSlot + 1;
        end
      end
    endcase
    mVon = video_on;
  endtask

  task automatic checkOutput();
    check("grant", 16'(grant), 16'(modelGrant()));
    check("frame_tick", 16'(frame_tick), 16'(mTick));
    check("busy", 16'(busy), 16'(mMode != 0));
    check("frame_count", frame_count, mFc);
    check("timeout_flag", 16'(timeout_flag), 16'(mTimeout));
    check("overrun", 16'(overrun), 16'(mOverrun));
  endtask

  task automatic applyStimulus(input logic von, input logic [9:0] y, input logic [3:0] r,
                               input logic [3:0] d, input logic clr);
    video_on  = von;
    y_control = y;
    req       = r;
    done      = d;
    flag_clr  = clr;
  endtask

  task automatic stepClock();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    int cnt;

    //             von  y        req      done     clr   grant    tick  busy  fc
    tbl[0]  = '{1'b1, 10'd478, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 10'd100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 10'd478, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0};
    tbl[3]  = '{1'b0, 10'd479, 4'b1011, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 16'd1};
    tbl[4]  = '{1'b0, 10'd479, 4'b1011, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1, 16'd1};
    tbl[5]  = '{1'b0, 10'd479, 4'b1011, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1, 16'd1};
    tbl[6]  = '{1'b0, 10'd479, 4'b1011, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1, 16'd1};
    tbl[7]  = '{1'b0, 10'd479, 4'b1011, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 16'd1};
    tbl[8]  = '{1'b0, 10'd479, 4'b1011, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b1, 16'd1};
    tbl[9]  = '{1'b0, 10'd479, 4'b1011, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b1, 16'd1};
    tbl[10] = '{1'b0, 10'd479, 4'b1011, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b1, 16'd1};
    tbl[11] = '{1'b0, 10'd479, 4'b1011, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b1, 16'd1};
    tbl[12] = '{1'b0, 10'd479, 4'b1011, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b1, 16'd1};
    tbl[13] = '{1'b0, 10'd479, 4'b1011, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b1, 16'd1};
    tbl[14] = '{1'b0, 10'd479, 4'b1011, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b1, 16'd1};
    tbl[15] = '{1'b0, 10'd479, 4'b1011, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b1, 16'd1};
    tbl[16] = '{1'b0, 10'd479, 4'b1011, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 16'd1};
    tbl[17] = '{1'b1, 10'd0,   4'b1011, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd1};
    tbl[18] = '{1'b0, 10'd479, 4'b1011, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 16'd2};
    tbl[19] = '{1'b0, 10'd479, 4'b1011, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1, 16'd2};
    tbl[20] = '{1'b0, 10'd479, 4'b1011, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 16'd2};

    reset = 1'b1;
    applyStimulus(1'b0, 10'd0, 4'b0000, 4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset.grant", 16'(grant), 16'h0);
    check("reset.busy", 16'(busy), 16'h0);
    check("reset.frame_count", frame_count, 16'h0);
    reset = 1'b0;
    modelReset();

    for (int r = 0; r < 21; r++) begin
      applyStimulus(tbl[r].von, tbl[r].y, tbl[r].req, tbl[r].done, tbl[r].clr);
      stepClock();
      check($sformatf("tbl%0d.grant", r), 16'(grant), 16'(tbl[r].eGrant));
      check($sformatf("tbl%0d.tick", r), 16'(frame_tick), 16'(tbl[r].eTick));
      check($sformatf("tbl%0d.busy", r), 16'(busy), 16'(tbl[r].eBusy));
      check($sformatf("tbl%0d.fc", r), frame_count, tbl[r].eFc);
    end

    // Slot timeout: requester 2 never completes, then requester 1 follows.
    applyStimulus(1'b0, 10'd479, 4'b0100, 4'b0000, 1'b0);
    stepClock();
    check("seqA.grant2", 16'(grant), 16'h4);
    applyStimulus(1'b0, 10'd479, 4'b0110, 4'b0000, 1'b0);
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (grant == 4'b0100) cnt++;
      else break;
      stepClock();
    end
    check("seqA.holdCycles", 16'(cnt), 16'd16);
    check("seqA.timeoutFlag", 16'(timeout_flag), 16'h4);
    stepClock();
    check("seqA.nextGrant", 16'(grant), 16'h2);

    // Window closes while requester 1 still holds the grant.
    applyStimulus(1'b1, 10'd479, 4'b0110, 4'b0000, 1'b0);
    stepClock();
    check("seqB.grant", 16'(grant), 16'h0);
    check("seqB.overrun", 16'(overrun), 16'h1);
    check("seqB.busy", 16'(busy), 16'h0);
    applyStimulus(1'b1, 10'd479, 4'b0110, 4'b0000, 1'b1);
    stepClock();
    check("seqB.overrunClr", 16'(overrun), 16'h0);
    check("seqB.timeoutClr", 16'(timeout_flag), 16'h0);

    // Stray done ignored; done and window close together count as served.
    applyStimulus(1'b0, 10'd479, 4'b0011, 4'b0000, 1'b0);
    stepClock();
    check("seqC.tick", 16'(frame_tick), 16'h1);
    check("seqC.fc", frame_count, 16'd3);
    stepClock();
    check("seqC.grant0", 16'(grant), 16'h1);
    applyStimulus(1'b0, 10'd479, 4'b0011, 4'b1000, 1'b0);
    stepClock();
    check("seqC.strayDone", 16'(grant), 16'h1);
    applyStimulus(1'b0, 10'd479, 4'b0011, 4'b0001, 1'b0);
    stepClock();
    check("seqC.done0", 16'(grant), 16'h0);
    applyStimulus(1'b0, 10'd479, 4'b0011, 4'b0000, 1'b0);
    stepClock();
    check("seqC.grant1", 16'(grant), 16'h2);
    applyStimulus(1'b1, 10'd479, 4'b0011, 4'b0010, 1'b0);
    stepClock();
    check("seqC.doneCloseGrant", 16'(grant), 16'h0);
    check("seqC.doneCloseOverrun", 16'(overrun), 16'h0);
    check("seqC.doneCloseBusy", 16'(busy), 16'h1);
    applyStimulus(1'b1, 10'd479, 4'b0011, 4'b0000, 1'b0);
    stepClock();
    applyStimulus(1'b0, 10'd479, 4'b0011, 4'b0000, 1'b0);
    stepClock();
    check("seqC.ignoredTick", 16'(frame_tick), 16'h0);
    check("seqC.ignoredFc", frame_count, 16'd3);

    // Asynchronous reset while a grant is held.
    applyStimulus(1'b0, 10'd479, 4'b0100, 4'b0000, 1'b0);
    stepClock();
    check("seqD.grant2", 16'(grant), 16'h4);
    #2;
    reset = 1'b1;
    #1;
    check("seqD.asyncGrant", 16'(grant), 16'h0);
    check("seqD.asyncBusy", 16'(busy), 16'h0);
    check("seqD.asyncTick", 16'(frame_tick), 16'h0);
    check("seqD.asyncFc", frame_count, 16'h0);
    check("seqD.asyncTimeout", 16'(timeout_flag), 16'h0);
    check("seqD.asyncOverrun", 16'(overrun), 16'h0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 10'd0, 4'b0000, 4'b0000, 1'b0);
    reset = 1'b0;
    modelReset();
    stepClock();

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] d;
      d = '0;
      for (int b = 0; b < NREQ; b++) begin
        d[b] = ($urandom_range(7, 0) == 0);
      end
      applyStimulus(($urandom_range(31, 0) == 0) ? ~video_on : video_on,
                    ($urandom_range(1, 0) == 1) ? 10'd479 : 10'($urandom_range(479, 0)),
                    4'($urandom), d, ($urandom_range(15, 0) == 0));
      stepClock();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
